// File: rtl/lut_cfg_ctrl.sv
// Truth-table loader and evaluator for one N_IN-input LUT cell, with serial config chain and scan-out.
// Optional self-test sweep (SIG / SWEEP_DONE) is built only when SELFTEST_EN is defined.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | unconfigured, out forced low, ready for a load
// S_LOAD   | shifting shadow word into cfg MSB first, old bits to scan_do
// S_ACTIVE | evaluating out <= cfg[in], ready for a reload or a sweep
// S_SWEEP  | copying cfg into sig one bit per edge (SELFTEST_EN only)
module lut_cfg_ctrl #(
  parameter int N_IN = 3,
  localparam int DEPTH = 2**N_IN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  input  logic [DEPTH-1:0] cfg_word,
  output logic             cfg_ready,
  input  logic [N_IN-1:0]  in,
  output logic             out,
  output logic             configured,
  output logic             scan_do
`ifdef SELFTEST_EN
  ,
  input  logic             sweep_req,
  output logic [DEPTH-1:0] sig,
  output logic             sweep_done
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_ACTIVE = 2'd2
`ifdef SELFTEST_EN
    ,
    S_SWEEP  = 2'd3
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [DEPTH-1:0] cfg_q, shadow_q;
  logic [N_IN-1:0]  cnt_q;
  logic             take;
  logic             last;
`ifdef SELFTEST_EN
  logic             start_sweep;
`endif

  // cnt_q counts remaining edges down; terminal count is zero
  assign last = (cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cfg_ready = 1'b0;
    take      = 1'b0;
`ifdef SELFTEST_EN
    start_sweep = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          take    = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (last) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          take    = 1'b1;
          state_d = S_LOAD;
        end
`ifdef SELFTEST_EN
        else if (sweep_req) begin
          start_sweep = 1'b1;
          state_d     = S_SWEEP;
        end
`endif
      end
`ifdef SELFTEST_EN
      S_SWEEP: begin
        if (last) state_d = S_ACTIVE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q      <= '0;
      shadow_q   <= '0;
      cnt_q      <= '0;
      out        <= 1'b0;
      configured <= 1'b0;
      scan_do    <= 1'b0;
`ifdef SELFTEST_EN
      sig        <= '0;
      sweep_done <= 1'b0;
`endif
    end else begin
`ifdef SELFTEST_EN
      sweep_done <= 1'b0;
`endif
      case (state_q)
        S_IDLE: out <= 1'b0;
        S_LOAD: begin
          // down-counting index into shadow gives MSB-first order
          cfg_q   <= {cfg_q[DEPTH-2:0], shadow_q[cnt_q]};
          scan_do <= cfg_q[DEPTH-1];
          cnt_q   <= cnt_q - 1'b1;
          if (last) configured <= 1'b1;
        end
        S_ACTIVE: out <= cfg_q[in];
`ifdef SELFTEST_EN
        S_SWEEP: begin
          // ~cnt_q walks idx upward from 0 as cnt_q counts down
          sig[~cnt_q] <= cfg_q[~cnt_q];
          cnt_q       <= cnt_q - 1'b1;
          if (last) sweep_done <= 1'b1;
        end
`endif
        default: ;
      endcase
      if (take) begin
        shadow_q <= cfg_word;
        cnt_q    <= N_IN'(DEPTH - 1);
      end
`ifdef SELFTEST_EN
      if (start_sweep) cnt_q <= N_IN'(DEPTH - 1);
`endif
    end
  end

endmodule

// File: tb/tb_lut_cfg_ctrl.sv
// Scoreboard bench for lut_cfg_ctrl (N_IN=3): loads, reloads, ignored requests, abort, back-to-back.
// The sweep scenario is compiled in when SELFTEST_EN is defined.
module tb_lut_cfg_ctrl;
  localparam int N_IN  = 3;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_valid = 1'b0;
  logic [DEPTH-1:0] cfg_word = '0;
  logic             cfg_ready;
  logic [N_IN-1:0]  in_v = '0;
  logic             out;
  logic             configured;
  logic             scan_do;
`ifdef SELFTEST_EN
  logic             sweep_req = 1'b0;
  logic [DEPTH-1:0] sig;
  logic             sweep_done;
`endif

  int checks = 0;
  int errors = 0;

  // bench model: resident table and whether the cell is evaluating
  logic [DEPTH-1:0] tbl_m = '0;
  bit               active_m = 1'b0;
  logic             exp_out_q[$];
  logic             exp_scan_q[$];

  lut_cfg_ctrl #(.N_IN(N_IN)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_word   (cfg_word),
    .cfg_ready  (cfg_ready),
    .in         (in_v),
    .out        (out),
    .configured (configured),
    .scan_do    (scan_do)
`ifdef SELFTEST_EN
    ,
    .sweep_req  (sweep_req),
    .sig        (sig),
    .sweep_done (sweep_done)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // starts and ends at a negedge; drives each index, checks out one edge later
  task automatic eval_all();
    logic e;
    for (int i = 0; i < DEPTH; i++) begin
      in_v = i[N_IN-1:0];
      exp_out_q.push_back(active_m ? tbl_m[i] : 1'b0);
      @(negedge clk);
      e = exp_out_q.pop_front();
      chk_val($sformatf("out_in%0d", i), 32'(out), 32'(e));
    end
  endtask

  // glitch: LOAD cycle (1-based) in which a 8'hAA request is presented, 0 = none
  task automatic do_load(input logic [DEPTH-1:0] word, input int glitch);
    logic hold;
    logic e;
    bit   was_active;
    chk_val("ready_pre", 32'(cfg_ready), 32'd1);
    was_active = active_m;
    hold = active_m ? tbl_m[in_v] : 1'b0;
    for (int j = 0; j < DEPTH; j++) exp_scan_q.push_back(tbl_m[DEPTH-1-j]);
    cfg_word  = word;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    chk_val("ready_low_k", 32'(cfg_ready), 32'd0);
    for (int c = 1; c <= DEPTH; c++) begin
      cfg_valid = (c == glitch);
      if (c == glitch) cfg_word = 8'hAA;
      @(negedge clk);
      cfg_valid = 1'b0;
      if (exp_scan_q.size() == 0) chk_val("scan_q_empty", 32'd1, 32'd0);
      else begin
        e = exp_scan_q.pop_front();
        chk_val($sformatf("scan_do_j%0d", c - 1), 32'(scan_do), 32'(e));
      end
      chk_val($sformatf("out_hold_c%0d", c), 32'(out), 32'(hold));
      chk_val($sformatf("ready_c%0d", c), 32'(cfg_ready), 32'(c == DEPTH));
      chk_val($sformatf("configured_c%0d", c), 32'(configured), 32'((c == DEPTH) || was_active));
    end
    tbl_m    = word;
    active_m = 1'b1;
  endtask

  // reset asserted mid-cycle during the 4th LOAD cycle
  task automatic do_abort(input logic [DEPTH-1:0] word);
    cfg_word  = word;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_val("abort_out", 32'(out), 32'd0);
    chk_val("abort_configured", 32'(configured), 32'd0);
    chk_val("abort_ready", 32'(cfg_ready), 32'd1);
    chk_val("abort_scan_do", 32'(scan_do), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tbl_m    = '0;
    active_m = 1'b0;
    exp_scan_q.delete();
  endtask

`ifdef SELFTEST_EN
  task automatic do_sweep();
    logic hold;
    hold = tbl_m[in_v];
    sweep_req = 1'b1;
    @(negedge clk);
    sweep_req = 1'b0;
    chk_val("sweep_ready_k", 32'(cfg_ready), 32'd0);
    for (int c = 1; c <= DEPTH; c++) begin
      @(negedge clk);
      chk_val($sformatf("sweep_ready_c%0d", c), 32'(cfg_ready), 32'(c == DEPTH));
      chk_val($sformatf("sweep_done_c%0d", c), 32'(sweep_done), 32'(c == DEPTH));
      chk_val($sformatf("sweep_out_c%0d", c), 32'(out), 32'(hold));
    end
    chk_val("sig", 32'(sig), 32'(tbl_m));
    @(negedge clk);
    chk_val("sweep_done_after", 32'(sweep_done), 32'd0);
    chk_val("ready_after_sweep", 32'(cfg_ready), 32'd1);
  endtask
`endif

  initial begin
    #1;
    chk_val("rst_out", 32'(out), 32'd0);
    chk_val("rst_configured", 32'(configured), 32'd0);
    chk_val("rst_scan_do", 32'(scan_do), 32'd0);
    chk_val("rst_ready", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    eval_all();                // idle: out stays 0
    do_load(8'h01, 0);         // NOR3
    eval_all();
    do_load(8'hFE, 0);         // OR3 reload, scan_do = 0,..,0,1
    eval_all();
    do_load(8'h01, 3);         // request during 3rd LOAD cycle is ignored
    eval_all();
    do_abort(8'h55);
    eval_all();
    do_load(8'h80, 0);
    eval_all();
    in_v = 3'd5;
    do_load(8'h3C, 0);         // back-to-back loads
    do_load(8'hC3, 0);
    eval_all();
`ifdef SELFTEST_EN
    do_load(8'h96, 0);
    in_v = 3'd1;
    @(negedge clk);
    do_sweep();
    eval_all();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lut_cfg_ctrl.md
# lut_cfg_ctrl

Configuration and evaluation controller for one N-input lookup-table logic cell, the same kind of cell that implements the 3-input gates in this design (e.g. NOR3 = truth table 8'h01). It accepts a parallel truth-table word over a valid/ready handshake and shifts it serially into the cell's configuration chain, MSB first. It then evaluates the cell with a registered output. The previous configuration is forwarded on a scan-out pin so that cells can be daisy-chained.

## Interface
- N_IN, 3, number of LUT inputs (legal 2..4); DEPTH = 2**N_IN configuration bits
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous, active-high reset
- CFG_VALID  in  1  truth-table load request
- CFG_WORD  in  DEPTH  truth table; bit i = output for input index i
- CFG_READY  out  1  controller accepts a load this cycle
- IN  in  N_IN  LUT input vector (index into truth table)
- OUT  out  1  registered LUT output
- CONFIGURED  out  1  a complete configuration is resident
- SCAN_DO  out  1  serial stream of the outgoing (old) configuration
- SWEEP_REQ  in  1  self-test request (only with SELFTEST_EN)
- SIG  out  DEPTH  self-test signature (only with SELFTEST_EN)
- SWEEP_DONE  out  1  one-cycle self-test completion pulse (only with SELFTEST_EN)

## Operation
- States: IDLE (unconfigured), LOAD, ACTIVE, SWEEP (SWEEP only with SELFTEST_EN).
- Reset (asynchronous, immediate):
  - State IDLE; config register, shadow, and counter all 0.
  - OUT=0, CONFIGURED=0, SCAN_DO=0, CFG_READY=1, SIG=0, SWEEP_DONE=0.
- CFG_READY=1 in IDLE and ACTIVE, 0 in LOAD and SWEEP.
- Handshake: a transfer occurs on an edge where CFG_VALID and CFG_READY are both 1.
  - CFG_WORD is captured into the shadow register and the state goes to LOAD with the counter at 0.
  - CFG_VALID while CFG_READY=0 is ignored.
- LOAD: each edge shifts cfg <= {cfg[DEPTH-2:0], shadow[DEPTH-1-cnt]} and sets SCAN_DO <= cfg[DEPTH-1].
  - When cnt = DEPTH-1, the next state is ACTIVE and CONFIGURED is set to 1.
  - After DEPTH shifts, cfg equals the captured word.
  - OUT holds its last value throughout LOAD.
- ACTIVE: OUT <= cfg[IN] on every edge.
  - A new handshake here starts a reload; CONFIGURED stays 1 during the reload.
- IDLE: OUT stays 0.
- SCAN_DO holds its last shifted bit outside LOAD.

## Timing
- Handshake at edge k:
  - CFG_READY=0 from after edge k.
  - Shifts occur at edges k+1..k+DEPTH.
  - ACTIVE, CONFIGURED=1 and CFG_READY=1 after edge k+DEPTH.
- Back-to-back loads are possible: a new handshake can complete at edge k+DEPTH+1.
- OUT latency is 1 cycle from IN in ACTIVE.
  - The first evaluation using the new table is at edge k+DEPTH+1.
- SCAN_DO: the old cfg bit DEPTH-1-j appears after edge k+1+j, for j = 0..DEPTH-1.
- Priority in ACTIVE: CFG_VALID over SWEEP_REQ.
- RST mid-LOAD or mid-SWEEP aborts the operation; the block returns to IDLE with CONFIGURED=0.

## Configuration
- Macro SELFTEST_EN.
- Defined:
  - SWEEP_REQ, SIG and SWEEP_DONE exist.
  - SWEEP_REQ=1 in ACTIVE (with no handshake that edge) enters SWEEP.
  - SWEEP runs for DEPTH edges with idx = 0..DEPTH-1, writing SIG[idx] <= cfg[idx]; OUT is held throughout.
  - SWEEP_DONE pulses for 1 cycle after the last edge, then the state returns to ACTIVE.
  - In a correct part, SIG equals the loaded word.
- Undefined: these ports and the SWEEP state are absent; SWEEP_REQ has no meaning.

## Test plan
- Reset: assert RST asynchronously mid-cycle -> OUT=0, CONFIGURED=0, SCAN_DO=0, CFG_READY=1 immediately.
- NOR3 load (N_IN=3):
  - Stimulus: CFG_WORD=8'h01 with CFG_VALID for 1 cycle.
  - Required: CFG_READY low for 8 cycles, then CONFIGURED=1.
  - Then step IN=0..7 one per cycle -> OUT=1 one cycle after IN=0 and 0 for IN=1..7.
- Reload 8'hFE (OR3) from ACTIVE with 8'h01 resident:
  - SCAN_DO sequence over the 8 LOAD cycles = 0,0,0,0,0,0,0,1.
  - OUT frozen during LOAD.
  - Afterwards OUT=0 only for IN=0.
- Ignored request: CFG_VALID with 8'hAA during the 3rd LOAD cycle of 8'h01 -> no effect; the resident table remains 8'h01.
- Abort: RST at the 4th LOAD cycle -> IDLE, CONFIGURED=0, OUT=0. A fresh load of 8'h80 then gives OUT=1 only for IN=7.
- SELFTEST_EN: load 8'h96, then SWEEP_REQ for 1 cycle -> CFG_READY low for 8 cycles, SIG=8'h96, one SWEEP_DONE pulse, back to ACTIVE.
